// File: rtl/mm_pkg.sv
// ----------------------------------------------------------------------------
// mm_pkg
// Shared definitions for the matrix-multiply job arbiter slice.
//   state_e          : job sequencer states
//   DEF_*            : default parameter values for the arbiter and its bus
//   id_width()       : width of a requester index (at least one bit)
// ----------------------------------------------------------------------------
package mm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_COMPLETE,
        ST_ABORT
    } state_e;

    localparam int DEF_NREQ        = 4;
    localparam int DEF_AW          = 32;
    localparam int DEF_TIMEOUT_CYC = 4096;

    // A single requester index still needs one bit to be a legal vector.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mm_job_arbiter_if.sv
// ----------------------------------------------------------------------------
// mm_job_arbiter_if
// Bundles the requester-side job handshake, the engine start/done/abort
// interface and the completion/status outputs of mm_job_arbiter.
//   slave  : the arbiter's view (drives ready, engine controls, completions)
//   master : the surrounding system's view (requesters plus the engine)
// ----------------------------------------------------------------------------
interface mm_job_arbiter_if
    import mm_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int AW   = DEF_AW
);
    localparam int IDW = id_width(NREQ);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ-1:0]    req_mode;
    logic               eng_start;
    logic [AW-1:0]      eng_addr;
    logic               eng_mode;
    logic               eng_done;
    logic               eng_abort;
    logic [NREQ-1:0]    cmp_valid;
    logic [NREQ-1:0]    cmp_error;
    logic               busy;
    logic [IDW-1:0]     active_id;

    modport slave (
        input  req_valid, req_addr, req_mode, eng_done,
        output req_ready, eng_start, eng_addr, eng_mode, eng_abort,
               cmp_valid, cmp_error, busy, active_id
    );

    modport master (
        output req_valid, req_addr, req_mode, eng_done,
        input  req_ready, eng_start, eng_addr, eng_mode, eng_abort,
               cmp_valid, cmp_error, busy, active_id
    );

endinterface

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker.
//   req   in  NREQ   request vector
//   ptr   in  IDW    highest-priority index this round
//   en    in  1      grant allowed
//   grant out NREQ   one-hot grant (zero when disabled or nothing requested)
//   id    out IDW    binary index of the granted requester (0 when none)
// ----------------------------------------------------------------------------
module rr_arbiter
    import mm_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
) (
    input  logic [NREQ-1:0]           req,
    input  logic [id_width(NREQ)-1:0] ptr,
    input  logic                      en,
    output logic [NREQ-1:0]           grant,
    output logic [id_width(NREQ)-1:0] id
);
    localparam int IDW = id_width(NREQ);

    logic found;

    // Scan cyclically starting at ptr; the first requester seen wins.
    always_comb begin
        grant = '0;
        id    = '0;
        found = 1'b0;
        for (int off = 0; off < NREQ; off++) begin
            if (en && !found && req[(int'(ptr) + off) % NREQ]) begin
                grant[(int'(ptr) + off) % NREQ] = 1'b1;
                id    = IDW'((int'(ptr) + off) % NREQ);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mm_job_arbiter.sv
// ----------------------------------------------------------------------------
// mm_job_arbiter
// Shares one matrix-multiply engine between NREQ job sources. A round-robin
// winner is accepted in IDLE, started with a one-cycle eng_start, watched by
// a watchdog while the engine runs, and finished with a completion pulse
// (cmp_error set when the watchdog expired and the engine was aborted).
//   clk  in  clock
//   rst  in  synchronous active-high reset
//   bus  slave modport of mm_job_arbiter_if (handshake, engine, completions)
// ----------------------------------------------------------------------------
module mm_job_arbiter
    import mm_pkg::*;
#(
    parameter int NREQ        = DEF_NREQ,
    parameter int AW          = DEF_AW,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic             clk,
    input  logic             rst,
    mm_job_arbiter_if.slave  bus
);
    localparam int IDW = id_width(NREQ);
    localparam int WDW = $clog2(TIMEOUT_CYC);

    state_e          state_q, state_d;
    logic [IDW-1:0]  ptr_q,   ptr_d;
    logic [IDW-1:0]  id_q,    id_d;
    logic [AW-1:0]   addr_q,  addr_d;
    logic            mode_q,  mode_d;
    logic [WDW-1:0]  wd_q,    wd_d;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  win_id;
    logic [IDW-1:0]  ptr_next;

    logic [NREQ-1:0] req_ready;
    logic            eng_start;
    logic            eng_abort;
    logic [NREQ-1:0] cmp_valid;
    logic [NREQ-1:0] cmp_error;

    // Grants are only meaningful in IDLE, so the arbiter is gated there.
    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req   (bus.req_valid),
        .ptr   (ptr_q),
        .en    (state_q == ST_IDLE),
        .grant (grant),
        .id    (win_id)
    );

    // After a job ends, priority moves to the requester just past its owner.
    assign ptr_next = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            addr_q  <= '0;
            mode_q  <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            mode_q  <= mode_d;
            wd_q    <= wd_d;
        end
    end

    // Sequencer: accept -> start -> wait (done or watchdog) -> report.
    // In WAIT, eng_done is tested before the watchdog so a simultaneous
    // done and expiry is reported as a normal completion.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        addr_d    = addr_q;
        mode_d    = mode_q;
        wd_d      = wd_q;
        req_ready = '0;
        eng_start = 1'b0;
        eng_abort = 1'b0;
        cmp_valid = '0;
        cmp_error = '0;
        case (state_q)
            ST_IDLE: begin
                req_ready = grant;
                if (|grant) begin
                    id_d    = win_id;
                    addr_d  = bus.req_addr[int'(win_id)*AW +: AW];
                    mode_d  = bus.req_mode[win_id];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                eng_start = 1'b1;
                wd_d      = '0;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                wd_d = wd_q + WDW'(1);
                if (bus.eng_done) begin
                    state_d = ST_COMPLETE;
                end else if (wd_q == WDW'(TIMEOUT_CYC - 1)) begin
                    state_d = ST_ABORT;
                end
            end
            ST_COMPLETE: begin
                cmp_valid[id_q] = 1'b1;
                ptr_d           = ptr_next;
                state_d         = ST_IDLE;
            end
            ST_ABORT: begin
                eng_abort       = 1'b1;
                cmp_valid[id_q] = 1'b1;
                cmp_error[id_q] = 1'b1;
                ptr_d           = ptr_next;
                state_d         = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.req_ready = req_ready;
    assign bus.eng_start = eng_start;
    assign bus.eng_abort = eng_abort;
    assign bus.cmp_valid = cmp_valid;
    assign bus.cmp_error = cmp_error;
    assign bus.eng_addr  = addr_q;
    assign bus.eng_mode  = mode_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.active_id = (state_q != ST_IDLE) ? id_q : '0;

endmodule

// File: tb/tb_mm_job_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mm_job_arbiter
// Randomized job traffic against mm_job_arbiter with a job-level reference
// model: the bench predicts each winner from the cyclic-priority rule, and
// each job's end (completion or abort) from when it pulses eng_done relative
// to the watchdog window.
// ----------------------------------------------------------------------------
module tb_mm_job_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 32;
    localparam int TMO  = 24;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mm_job_arbiter_if #(.NREQ(NREQ), .AW(AW)) bus ();

    mm_job_arbiter #(.NREQ(NREQ), .AW(AW), .TIMEOUT_CYC(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state: next priority index and last issued job.
    int            exp_ptr;
    logic [AW-1:0] exp_addr;
    logic          exp_mode;

    logic [AW-1:0] addr_tbl [NREQ];
    logic          mode_tbl [NREQ];

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic int pickWinner(input logic [NREQ-1:0] mask, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (mask[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic randomizeJobs();
        for (int i = 0; i < NREQ; i++) begin
            addr_tbl[i] = $urandom;
            mode_tbl[i] = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic driveJobs();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_addr[i*AW +: AW] = addr_tbl[i];
            bus.req_mode[i]          = mode_tbl[i];
        end
    endtask

    // One full job. done_at is the WAIT cycle index at which the bench pulses
    // eng_done (negative or >= TMO means the engine never answers in time).
    task automatic applyStimulus(input logic [NREQ-1:0] mask, input int done_at,
                                 input bit spur_idle, input bit spur_issue);
        int              win;
        int              n_wait;
        bit              abort_exp;
        logic [NREQ-1:0] onehot;

        driveJobs();
        bus.req_valid = mask;
        bus.eng_done  = spur_idle;
        win    = pickWinner(mask, exp_ptr);
        onehot = '0;
        if (win >= 0) onehot[win] = 1'b1;
        #1;
        checkOutput("idle_busy", bus.busy, 0);
        checkOutput("accept_ready", bus.req_ready, onehot);
        checkOutput("idle_hold_addr", {bus.eng_mode, bus.eng_addr}, {exp_mode, exp_addr});
        stepCycle();
        if (win < 0) begin
            bus.req_valid = '0;
            bus.eng_done  = 1'b0;
            return;
        end
        exp_addr = addr_tbl[win];
        exp_mode = mode_tbl[win];

        // Losers keep asking; the winner's inputs change to prove they were latched.
        bus.req_valid = mask & ~onehot;
        bus.eng_done  = spur_issue;
        bus.req_addr[win*AW +: AW] = $urandom;
        bus.req_mode[win]          = ~mode_tbl[win];
        #1;
        checkOutput("issue_start", bus.eng_start, 1);
        checkOutput("issue_job", {bus.eng_mode, bus.eng_addr}, {exp_mode, exp_addr});
        checkOutput("issue_id", bus.active_id, win);
        checkOutput("issue_quiet", {bus.req_ready, bus.cmp_valid, bus.eng_abort}, 0);
        stepCycle();

        abort_exp = !(done_at >= 0 && done_at < TMO);
        n_wait    = abort_exp ? TMO : done_at + 1;
        for (int k = 0; k < n_wait; k++) begin
            bus.eng_done = (k == done_at);
            #1;
            checkOutput("wait_outputs",
                        {bus.eng_start, bus.eng_abort, bus.cmp_valid, bus.req_ready, bus.busy},
                        {1'b0, 1'b0, {NREQ{1'b0}}, {NREQ{1'b0}}, 1'b1});
            checkOutput("wait_job", {bus.eng_mode, bus.eng_addr}, {exp_mode, exp_addr});
            stepCycle();
        end

        bus.eng_done = 1'($urandom_range(0, 1));
        #1;
        checkOutput("end_cmp_valid", bus.cmp_valid, onehot);
        checkOutput("end_cmp_error", bus.cmp_error, abort_exp ? onehot : '0);
        checkOutput("end_abort", bus.eng_abort, abort_exp);
        checkOutput("end_status", {bus.busy, bus.eng_start, bus.req_ready}, {1'b1, 1'b0, {NREQ{1'b0}}});
        exp_ptr = (win + 1) % NREQ;
        stepCycle();
        bus.eng_done  = 1'b0;
        bus.req_valid = '0;
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) begin
            bus.req_valid = '0;
            bus.eng_done  = 1'($urandom_range(0, 1));
            #1;
            checkOutput("gap_quiet",
                        {bus.busy, bus.req_ready, bus.cmp_valid, bus.eng_abort, bus.eng_start},
                        0);
            stepCycle();
        end
        bus.eng_done = 1'b0;
    endtask

    task automatic resetMidJob();
        randomizeJobs();
        driveJobs();
        bus.req_valid = 4'b1010;
        stepCycle();
        bus.req_valid = '0;
        stepCycle();
        for (int k = 0; k < 5; k++) stepCycle();
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        #1;
        checkOutput("rst_outputs",
                    {bus.busy, bus.active_id, bus.req_ready, bus.eng_start, bus.eng_abort,
                     bus.cmp_valid, bus.cmp_error, bus.eng_mode, bus.eng_addr},
                    0);
        exp_ptr  = 0;
        exp_addr = '0;
        exp_mode = 1'b0;
        stepCycle();
        idleCycles(TMO + 4);
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_mode  = '0;
        bus.eng_done  = 1'b0;
        exp_ptr       = 0;
        exp_addr      = '0;
        exp_mode      = 1'b0;
        stepCycle();
        stepCycle();
        checkOutput("reset_outputs",
                    {bus.busy, bus.active_id, bus.req_ready, bus.eng_start, bus.eng_abort,
                     bus.cmp_valid, bus.cmp_error, bus.eng_mode, bus.eng_addr},
                    0);
        rst = 1'b0;
        stepCycle();

        $display("[TB] single job on requester 2");
        randomizeJobs();
        addr_tbl[2] = 32'h100;
        mode_tbl[2] = 1'b1;
        applyStimulus(4'b0100, 19, 1'b0, 1'b0);

        $display("[TB] fairness with all requesters valid");
        for (int j = 0; j < 8; j++) begin
            randomizeJobs();
            applyStimulus(4'b1111, 4, 1'b0, 1'b0);
        end

        $display("[TB] watchdog timeout then next grant");
        randomizeJobs();
        applyStimulus(4'b0011, -1, 1'b0, 1'b0);
        randomizeJobs();
        applyStimulus(4'b0011, 2, 1'b0, 1'b0);

        $display("[TB] done on expiry cycle");
        randomizeJobs();
        applyStimulus(4'b1000, TMO - 1, 1'b0, 1'b0);

        $display("[TB] spurious done in idle and issue");
        idleCycles(3);
        randomizeJobs();
        applyStimulus(4'b0110, 7, 1'b1, 1'b1);

        $display("[TB] reset during wait");
        resetMidJob();
        randomizeJobs();
        applyStimulus(4'b1111, 3, 1'b0, 1'b0);

        $display("[TB] randomized jobs");
        for (int j = 0; j < 40; j++) begin
            int r;
            int d;
            r = int'($urandom_range(0, 9));
            if (r < 6)       d = int'($urandom_range(0, TMO - 2));
            else if (r == 6) d = TMO - 1;
            else if (r == 7) d = -1;
            else             d = int'($urandom_range(TMO, TMO + 5));
            randomizeJobs();
            applyStimulus(NREQ'($urandom_range(1, (1 << NREQ) - 1)), d,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            idleCycles(int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
